// File: rtl/bit_count_frame_accum_pkg.sv
// Shared defaults and FSM encoding for the bit-count frame accumulator.
// Imported by the saturating adder and by the accumulator top.
package bit_count_pkg;

   localparam int DEF_CNT_W  = 6;
   localparam int DEF_SUM_W  = 16;
   localparam int DEF_WCNT_W = 10;

   localparam logic ST_IDLE_ENC  = 1'b0;
   localparam logic ST_ACCUM_ENC = 1'b1;

   typedef enum logic {
      ST_IDLE  = ST_IDLE_ENC,
      ST_ACCUM = ST_ACCUM_ENC
   } state_t;

endpackage

// File: rtl/bit_count_sat_add.sv
// Unsigned W-bit adder that clamps to all-ones on carry-out.
// Reports the clamp so the caller can keep a sticky overflow flag.
module bit_count_sat_add
   import bit_count_pkg::*;
#(
   parameter int W = DEF_SUM_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         sat
);

   logic [W:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b};
      sat  = full[W];
      sum  = full[W] ? {W{1'b1}} : full[W-1:0];
   end

endmodule

// File: rtl/bit_count_frame_accum.sv
// Accumulates per-word bit counts into per-frame total, word count and peak,
// and presents one result per frame on a valid/ready output register.
module bit_count_frame_accum
   import bit_count_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int SUM_W  = DEF_SUM_W,
   parameter int WCNT_W = DEF_WCNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CNT_W-1:0]  in_cnt,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  out_sum,
   output logic [WCNT_W-1:0] out_words,
   output logic [CNT_W-1:0]  out_peak,
   output logic              out_ovf
);

   state_t state, next_state;

   logic [SUM_W-1:0]  acc_sum, new_sum;
   logic [WCNT_W-1:0] acc_words, new_words;
   logic [CNT_W-1:0]  acc_peak, new_peak;
   logic              acc_ovf, new_ovf;
   logic              sum_sat, words_sat;
   logic              accept;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Accumulators are held at zero while no frame is open, so the first beat
   // of a frame falls out of the same adders as every later beat.
   bit_count_sat_add #(.W(SUM_W)) u_sum_add (
      .a   (acc_sum),
      .b   (SUM_W'(in_cnt)),
      .sum (new_sum),
      .sat (sum_sat)
   );

   bit_count_sat_add #(.W(WCNT_W)) u_words_add (
      .a   (acc_words),
      .b   (WCNT_W'(1)),
      .sum (new_words),
      .sat (words_sat)
   );

   assign new_peak = (in_cnt > acc_peak) ? in_cnt : acc_peak;
   assign new_ovf  = acc_ovf || sum_sat || words_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (accept) begin
         next_state = in_last ? ST_IDLE : ST_ACCUM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_sum   <= '0;
         acc_words <= '0;
         acc_peak  <= '0;
         acc_ovf   <= 1'b0;
      end else if (accept) begin
         if (in_last) begin
            acc_sum   <= '0;
            acc_words <= '0;
            acc_peak  <= '0;
            acc_ovf   <= 1'b0;
         end else begin
            acc_sum   <= new_sum;
            acc_words <= new_words;
            acc_peak  <= new_peak;
            acc_ovf   <= new_ovf;
         end
      end
   end

   // A closing beat reloads the result even while the old one is leaving,
   // which keeps single-beat frames flowing at one per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_words <= '0;
         out_peak  <= '0;
         out_ovf   <= 1'b0;
      end else if (accept && in_last) begin
         out_valid <= 1'b1;
         out_sum   <= new_sum;
         out_words <= new_words;
         out_peak  <= new_peak;
         out_ovf   <= new_ovf;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bit_count_frame_accum.sv
// Drives a default-width and an 8-bit-sum accumulator side by side and checks
// both against a frame-list reference model every cycle.
module tb_bit_count_frame_accum;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [5:0] in_cnt;
   logic       in_last;
   logic       out_ready;

   logic        in_ready16, out_valid16, out_ovf16;
   logic [15:0] out_sum16;
   logic [9:0]  out_words16;
   logic [5:0]  out_peak16;

   logic        in_ready8, out_valid8, out_ovf8;
   logic [7:0]  out_sum8;
   logic [9:0]  out_words8;
   logic [5:0]  out_peak8;

   int total = 0;
   int bad   = 0;

   // Reference model state: beats of the open frame plus the held result.
   int q[$];
   bit exp_valid = 1'b0;
   int exp_sum16, exp_sum8, exp_words, exp_peak;
   bit exp_ovf16, exp_ovf8;

   always #5 clk = ~clk;

   bit_count_frame_accum dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready16),
      .in_cnt    (in_cnt),
      .in_last   (in_last),
      .out_valid (out_valid16),
      .out_ready (out_ready),
      .out_sum   (out_sum16),
      .out_words (out_words16),
      .out_peak  (out_peak16),
      .out_ovf   (out_ovf16)
   );

   bit_count_frame_accum #(.SUM_W(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready8),
      .in_cnt    (in_cnt),
      .in_last   (in_last),
      .out_valid (out_valid8),
      .out_ready (out_ready),
      .out_sum   (out_sum8),
      .out_words (out_words8),
      .out_peak  (out_peak8),
      .out_ovf   (out_ovf8)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // A frame result is just arithmetic over the list of its beats.
   task automatic closeFrame();
      int tot = 0;
      int pk  = 0;
      int n   = q.size();
      foreach (q[i]) begin
         tot += q[i];
         if (q[i] > pk) pk = q[i];
      end
      exp_sum16 = (tot > 65535) ? 65535 : tot;
      exp_sum8  = (tot > 255) ? 255 : tot;
      exp_words = (n > 1023) ? 1023 : n;
      exp_peak  = pk;
      exp_ovf16 = (tot > 65535) || (n > 1023);
      exp_ovf8  = (tot > 255) || (n > 1023);
      exp_valid = 1'b1;
      q.delete();
   endtask

   task automatic checkResult();
      checkOutput("valid16", 32'(out_valid16), 32'(exp_valid));
      checkOutput("valid8", 32'(out_valid8), 32'(exp_valid));
      if (exp_valid) begin
         checkOutput("sum16", 32'(out_sum16), exp_sum16);
         checkOutput("sum8", 32'(out_sum8), exp_sum8);
         checkOutput("words16", 32'(out_words16), exp_words);
         checkOutput("words8", 32'(out_words8), exp_words);
         checkOutput("peak16", 32'(out_peak16), exp_peak);
         checkOutput("peak8", 32'(out_peak8), exp_peak);
         checkOutput("ovf16", 32'(out_ovf16), 32'(exp_ovf16));
         checkOutput("ovf8", 32'(out_ovf8), 32'(exp_ovf8));
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_valid16", 32'(out_valid16), 0);
      checkOutput("rst_valid8", 32'(out_valid8), 0);
      checkOutput("rst_sum16", 32'(out_sum16), 0);
      checkOutput("rst_sum8", 32'(out_sum8), 0);
      checkOutput("rst_words", 32'(out_words16), 0);
      checkOutput("rst_peak", 32'(out_peak16), 0);
      checkOutput("rst_ovf", 32'(out_ovf16), 0);
      checkOutput("rst_ready", 32'(in_ready16), 1);
   endtask

   // One clock cycle: drive, check in_ready mid-cycle, step model on the edge,
   // then check the registered outputs just after it.
   task automatic applyStimulus(input bit v, input int c, input bit l, input bit r);
      bit exp_ready;
      bit accept;
      in_valid  = v;
      in_cnt    = 6'(c);
      in_last   = l;
      out_ready = r;
      @(negedge clk);
      exp_ready = !exp_valid || r;
      checkOutput("in_ready16", 32'(in_ready16), 32'(exp_ready));
      checkOutput("in_ready8", 32'(in_ready8), 32'(exp_ready));
      accept = v && exp_ready;
      @(posedge clk);
      if (accept) q.push_back(c);
      if (accept && l) closeFrame();
      else if (r) exp_valid = 1'b0;
      #1;
      checkResult();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_cnt    = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkResetState();
      rst_n = 1'b1;

      // Reset mid-frame discards the partial frame.
      applyStimulus(1, 5, 0, 1);
      applyStimulus(1, 7, 0, 1);
      applyStimulus(1, 9, 0, 1);
      rst_n = 1'b0;
      q.delete();
      exp_valid = 1'b0;
      #1;
      checkResetState();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1, 4, 1, 1);
      applyStimulus(0, 0, 0, 1);

      // Basic four-beat frame including boundary counts 32 and 0.
      applyStimulus(1, 32, 0, 1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 17, 0, 1);
      applyStimulus(1, 1, 1, 1);
      applyStimulus(0, 0, 0, 1);

      // Backpressure: result held, inputs stalled for 10 cycles.
      applyStimulus(1, 20, 1, 0);
      for (int i = 0; i < 10; i++) applyStimulus(1, 7, 1, 0);
      applyStimulus(1, 7, 0, 1);
      applyStimulus(1, 3, 1, 1);
      applyStimulus(0, 0, 0, 1);

      // Back-to-back single-beat frames.
      applyStimulus(1, 3, 1, 1);
      applyStimulus(1, 8, 1, 1);
      applyStimulus(1, 12, 1, 1);
      applyStimulus(0, 0, 0, 1);

      // Sum saturation on the 8-bit instance, then a clean frame.
      for (int i = 0; i < 8; i++) applyStimulus(1, 32, 0, 1);
      applyStimulus(1, 32, 1, 1);
      applyStimulus(1, 1, 1, 1);
      applyStimulus(0, 0, 0, 1);

      // Idle gaps inside a frame.
      applyStimulus(1, 2, 0, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 6, 1, 1);
      applyStimulus(0, 0, 0, 1);

      // Word counter saturation.
      for (int i = 0; i < 1029; i++) applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 5, 1, 1);
      applyStimulus(0, 0, 0, 1);

      // Random traffic, including counts above 32.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
                       bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 2) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
